stream_demux: RTL

- Reverse of the 2-bit select mux: takes one 2-bit symbol stream and steers each symbol to one of two output channels.
- The `enable` input picks the channel: 0 selects channel 1, 1 selects channel 2.
- Each channel has its own small FIFO, with valid/ready handshakes on the input and on both outputs.
- Sits between the game-input source and two independent consumers (e.g. player-1 / player-2 logic). A stall on one channel must not stall the other.

---
 rtl/stream_demux.sv | 116 +++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// One symbol stream steered into two independent FIFO channels by `enable`.
// Optional DEMUX_STATS_EN adds saturating per-channel accept counters.
module stream_demux #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             enable,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]       count1,
    output logic [7:0]       count2
`endif
);

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]    wp_q  [2];
    logic [AW-1:0]    wp_d  [2];
    logic [AW-1:0]    rp_q  [2];
    logic [AW-1:0]    rp_d  [2];
    logic [AW:0]      cnt_q [2];
    logic [AW:0]      cnt_d [2];
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       push;
    logic [1:0]       pop;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]  = (cnt_q[c] == (AW+1)'(DEPTH));
            empty[c] = (cnt_q[c] == '0);
        end
    end

    // Readiness looks only at stored occupancy; a same-cycle pop does not help.
    assign in_ready = enable ? !full[1] : !full[0];

    assign push[0] = in_valid && in_ready && !enable;
    assign push[1] = in_valid && in_ready && enable;
    assign pop[0]  = !empty[0] && out1_ready;
    assign pop[1]  = !empty[1] && out2_ready;

    assign out1_valid = !empty[0];
    assign out2_valid = !empty[1];
    assign out1       = empty[0] ? '0 : mem_q[0][rp_q[0]];
    assign out2       = empty[1] ? '0 : mem_q[1][rp_q[1]];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            wp_d[c]  = wp_q[c] + AW'(push[c]);
            rp_d[c]  = rp_q[c] + AW'(pop[c]);
            cnt_d[c] = cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
                cnt_q[c] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[c][j] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                wp_q[c]  <= wp_d[c];
                rp_q[c]  <= rp_d[c];
                cnt_q[c] <= cnt_d[c];
                if (push[c]) begin
                    mem_q[c][wp_q[c]] <= in;
                end
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [7:0] st_q [2];
    logic [7:0] st_d [2];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c] = st_q[c];
            if (push[c] && (st_q[c] != 8'hFF)) begin
                st_d[c] = st_q[c] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q[0] <= '0;
            st_q[1] <= '0;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
        end
    end

    assign count1 = st_q[0];
    assign count2 = st_q[1];
`endif

endmodule
